// File: rtl/game_pkg.sv
// Shared screen encodings and sequencer state type for the game-flow logic.
// The screen_sel encodings are also used by the top-level rgb/hsync/vsync mux.
package game_pkg;

  localparam logic [1:0] SCR_START = 2'b00;
  localparam logic [1:0] SCR_PLAY  = 2'b01;
  localparam logic [1:0] SCR_END   = 2'b10;

  typedef enum logic [2:0] {
    ST_START,
    ST_ARM_PLAY,
    ST_PLAY,
    ST_ARM_END,
    ST_END,
    ST_ARM_START
  } seq_state_t;

  // ARM_* states keep showing the screen they are leaving until the frame boundary.
  function automatic logic [1:0] state_to_sel(input seq_state_t s);
    case (s)
      ST_PLAY, ST_ARM_END:  return SCR_PLAY;
      ST_END, ST_ARM_START: return SCR_END;
      default:              return SCR_START;
    endcase
  endfunction

endpackage

// File: rtl/screen_sequencer_if.sv
// Game-flow signals between the sequencer, the button/game core/VGA timing and the screen mux.
// master = the sequencer itself, slave = everything around it.
interface screen_sequencer_if;

  logic       start_btn;
  logic       stopped;
  logic       frame_start;
  logic [1:0] screen_sel;
  logic       en_start;
  logic       en_play;
  logic       en_end;
  logic       game_rst;
  logic       buzz_en;

  modport master (
    input  start_btn, stopped, frame_start,
    output screen_sel, en_start, en_play, en_end, game_rst, buzz_en
  );

  modport slave (
    output start_btn, stopped, frame_start,
    input  screen_sel, en_start, en_play, en_end, game_rst, buzz_en
  );

endinterface

// File: rtl/btn_debounce.sv
// Synchronizes and debounces a raw pushbutton and emits a 1-cycle pulse on each accepted press.
// A clean raw rising edge yields o_press DEBOUNCE_CYCLES+3 cycles later; releases emit nothing.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk_100MHz,
  input  logic reset,
  input  logic i_btn,
  output logic o_press
);

  localparam int             CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_db;
  logic          r_db_d;
  logic          r_press;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_db    <= 1'b0;
      r_db_d  <= 1'b0;
      r_press <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
      r_db_d  <= r_db;
      r_press <= r_db & ~r_db_d;
      // Any sample that agrees with the accepted level is a bounce and restarts the count.
      if (r_sync2 == r_db) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_cnt <= '0;
        r_db  <= r_sync2;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_press = r_press;

endmodule

// File: rtl/screen_sequencer.sv
// START -> PLAY -> END game-flow FSM switching screens only on frame_start, with buzzer and END timeout.
// Outputs are registered from the next state, so screen_sel/enables move the cycle after the frame_start.
module screen_sequencer
  import game_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES    = 1_000_000,
  parameter int BUZZ_CYCLES        = 50_000_000,
  parameter int END_TIMEOUT_FRAMES = 600
) (
  input  logic               clk_100MHz,
  input  logic               reset,
  screen_sequencer_if.master bus
);

  localparam int            BW         = (BUZZ_CYCLES > 0) ? $clog2(BUZZ_CYCLES + 1) : 1;
  localparam int            FW         = (END_TIMEOUT_FRAMES > 0) ? $clog2(END_TIMEOUT_FRAMES + 1) : 1;
  localparam logic [BW-1:0] BUZZ_LOAD  = BW'(BUZZ_CYCLES);
  localparam logic [FW-1:0] FRAME_LAST = (END_TIMEOUT_FRAMES > 0) ? FW'(END_TIMEOUT_FRAMES - 1) : '0;
  localparam bit            TIMEOUT_EN = (END_TIMEOUT_FRAMES != 0);

  seq_state_t    r_state;
  seq_state_t    w_state_nxt;
  logic [BW-1:0] r_buzz;
  logic [BW-1:0] w_buzz_nxt;
  logic [FW-1:0] r_frame;
  logic [FW-1:0] w_frame_nxt;
  logic          w_press;
  logic          w_timeout;
  logic [1:0]    w_sel_nxt;
  logic          w_game_rst_nxt;
  logic          w_buzz_en_nxt;
  logic [1:0]    r_screen_sel;
  logic          r_game_rst;
  logic          r_buzz_en;

  btn_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_btn_debounce (
    .clk_100MHz (clk_100MHz),
    .reset      (reset),
    .i_btn      (bus.start_btn),
    .o_press    (w_press)
  );

  assign w_timeout = TIMEOUT_EN && bus.frame_start && (r_frame == FRAME_LAST);

  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      r_state <= ST_START;
      r_buzz  <= '0;
      r_frame <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_buzz  <= w_buzz_nxt;
      r_frame <= w_frame_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_START:     if (w_press)              w_state_nxt = ST_ARM_PLAY;
      ST_ARM_PLAY:  if (bus.frame_start)      w_state_nxt = ST_PLAY;
      ST_PLAY:      if (bus.stopped)          w_state_nxt = ST_ARM_END;
      ST_ARM_END:   if (bus.frame_start)      w_state_nxt = ST_END;
      ST_END:       if (w_press || w_timeout) w_state_nxt = ST_ARM_START;
      ST_ARM_START: if (bus.frame_start)      w_state_nxt = ST_START;
      default:                                w_state_nxt = ST_START;
    endcase

    // Both counters only live inside END; entering END loads them, leaving clears them.
    w_buzz_nxt  = '0;
    w_frame_nxt = '0;
    if (w_state_nxt == ST_END) begin
      if (r_state != ST_END) begin
        w_buzz_nxt = BUZZ_LOAD;
      end else begin
        w_buzz_nxt  = (r_buzz != '0) ? r_buzz - 1'b1 : '0;
        w_frame_nxt = r_frame;
        if (TIMEOUT_EN && bus.frame_start) w_frame_nxt = r_frame + 1'b1;
      end
    end
  end

  always_comb begin
    w_sel_nxt      = state_to_sel(w_state_nxt);
    w_game_rst_nxt = !((w_state_nxt == ST_PLAY) || (w_state_nxt == ST_ARM_END));
    w_buzz_en_nxt  = (w_state_nxt == ST_END) && (w_buzz_nxt != '0);
  end

  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      r_screen_sel <= SCR_START;
      r_game_rst   <= 1'b1;
      r_buzz_en    <= 1'b0;
    end else begin
      r_screen_sel <= w_sel_nxt;
      r_game_rst   <= w_game_rst_nxt;
      r_buzz_en    <= w_buzz_en_nxt;
    end
  end

  assign bus.screen_sel = r_screen_sel;
  assign bus.en_start   = (r_screen_sel == SCR_START);
  assign bus.en_play    = (r_screen_sel == SCR_PLAY);
  assign bus.en_end     = (r_screen_sel == SCR_END);
  assign bus.game_rst   = r_game_rst;
  assign bus.buzz_en    = r_buzz_en;

endmodule
